// File: rtl/gb_fetch_pkg.sv
// Shared types and decode helpers for the LR35902 instruction fetch stage.
// Holds the fetch state encoding, the CB prefix constant and the immediate-length table.
package gb_fetch_pkg;

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_CB,
        FETCH_LO,
        FETCH_HI,
        ISSUE
    } fetch_state_e;

    localparam logic [7:0] CB_PREFIX = 8'hCB;

    // Number of immediate bytes following a non-prefixed opcode; undefined opcodes carry none.
    function automatic logic [1:0] imm_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd0;
        case (op)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'hE0, 8'hF0, 8'hE8, 8'hF8:
                len = 2'd1;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC,
            8'hEA, 8'hFA:
                len = 2'd2;
            default:
                len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register for the fetch stage.
// Reset load wins over redirect, which wins over increment; increment wraps modulo 2^ADDR_W.
module fetch_pc #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// LR35902 fetch stage: reads opcode, optional CB byte and immediates over a req/ack port,
// then holds the assembled instruction until decode takes it or execute redirects the PC.
module instr_fetch
    import gb_fetch_pkg::*;
#(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    input  logic              mem_rd_ack,
    input  logic [7:0]        mem_rd_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [7:0]        op,
    output logic              op_cb,
    output logic [7:0]        cb_op,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] op_pc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr
);

    fetch_state_e      state_d, state_q;
    logic              mem_rd_req_d, mem_rd_req_q;
    logic              op_valid_d, op_valid_q;
    logic [7:0]        op_d, op_q;
    logic              op_cb_d, op_cb_q;
    logic [7:0]        cb_op_d, cb_op_q;
    logic [15:0]       imm_d, imm_q;
    logic [ADDR_W-1:0] op_pc_d, op_pc_q;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;
    logic              byte_ok;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk       (clk),
        .rst       (rst),
        .inc       (pc_inc),
        .load      (jump_en),
        .load_addr (jump_addr),
        .pc        (pc)
    );

    // A byte only counts if we were actually requesting and no redirect is discarding it.
    assign byte_ok = mem_rd_req_q && mem_rd_ack && !jump_en;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        op_cb_d = op_cb_q;
        cb_op_d = cb_op_q;
        imm_d   = imm_q;
        op_pc_d = op_pc_q;
        pc_inc  = 1'b0;

        case (state_q)
            FETCH_OP: begin
                if (byte_ok) begin
                    op_d    = mem_rd_data;
                    op_pc_d = pc;
                    pc_inc  = 1'b1;
                    if (mem_rd_data == CB_PREFIX) begin
                        state_d = FETCH_CB;
                    end else if (imm_len(mem_rd_data) == 2'd0) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = FETCH_LO;
                    end
                end
            end
            FETCH_CB: begin
                if (byte_ok) begin
                    cb_op_d = mem_rd_data;
                    op_cb_d = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ISSUE;
                end
            end
            FETCH_LO: begin
                if (byte_ok) begin
                    imm_d[7:0] = mem_rd_data;
                    pc_inc     = 1'b1;
                    state_d    = (imm_len(op_q) == 2'd2) ? FETCH_HI : ISSUE;
                end
            end
            FETCH_HI: begin
                if (byte_ok) begin
                    imm_d[15:8] = mem_rd_data;
                    pc_inc      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (op_ready) begin
                    state_d = FETCH_OP;
                    op_cb_d = 1'b0;
                    cb_op_d = 8'h00;
                    imm_d   = 16'h0000;
                end
            end
            default: begin
                state_d = FETCH_OP;
            end
        endcase

        // A redirect abandons whatever was being assembled, after any same-cycle handshake.
        if (jump_en) begin
            state_d = FETCH_OP;
            op_cb_d = 1'b0;
            cb_op_d = 8'h00;
            imm_d   = 16'h0000;
        end

        mem_rd_req_d = (state_d != ISSUE);
        op_valid_d   = (state_d == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_OP;
            mem_rd_req_q <= 1'b0;
            op_valid_q   <= 1'b0;
            op_q         <= 8'h00;
            op_cb_q      <= 1'b0;
            cb_op_q      <= 8'h00;
            imm_q        <= 16'h0000;
            op_pc_q      <= RESET_PC;
        end else begin
            state_q      <= state_d;
            mem_rd_req_q <= mem_rd_req_d;
            op_valid_q   <= op_valid_d;
            op_q         <= op_d;
            op_cb_q      <= op_cb_d;
            cb_op_q      <= cb_op_d;
            imm_q        <= imm_d;
            op_pc_q      <= op_pc_d;
        end
    end

    assign mem_addr   = pc;
    assign mem_rd_req = mem_rd_req_q;
    assign op_valid   = op_valid_q;
    assign op         = op_q;
    assign op_cb      = op_cb_q;
    assign cb_op      = cb_op_q;
    assign imm        = imm_q;
    assign op_pc      = op_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a byte-array memory with programmable wait states,
// and a queue of expected instructions derived from memory contents and the opcode length table.
module tb_instr_fetch;

    localparam int ADDR_W = 16;

    localparam logic [7:0] ONE_BYTE [25] = '{
        8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
        8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
        8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hF0, 8'hE8, 8'hF8};
    localparam logic [7:0] TWO_BYTE [17] = '{
        8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
        8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC,
        8'hEA, 8'hFA};

    typedef struct packed {
        logic [7:0]  op;
        logic        cb;
        logic [7:0]  cb_op;
        logic [15:0] imm;
        logic [15:0] pc;
    } instr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_req;
    logic              mem_rd_ack = 1'b0;
    logic [7:0]        mem_rd_data = 8'h00;
    logic              op_valid;
    logic              op_ready = 1'b0;
    logic [7:0]        op;
    logic              op_cb;
    logic [7:0]        cb_op;
    logic [15:0]       imm;
    logic [ADDR_W-1:0] op_pc;
    logic              jump_en = 1'b0;
    logic [ADDR_W-1:0] jump_addr = '0;

    int checks = 0;
    int fails  = 0;
    int wait_states = 0;
    int ready_delay = 0;
    int issued = 0;

    logic [7:0] mem [0:65535];
    instr_t     exp_q[$];
    instr_t     last;

    instr_fetch #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_data (mem_rd_data),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op          (op),
        .op_cb       (op_cb),
        .cb_op       (cb_op),
        .imm         (imm),
        .op_pc       (op_pc),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int modelLen(input logic [7:0] o);
        for (int i = 0; i < 25; i++) if (ONE_BYTE[i] == o) return 1;
        for (int i = 0; i < 17; i++) if (TWO_BYTE[i] == o) return 2;
        return 0;
    endfunction

    // Walk memory from start and queue the instructions decode should receive, in order.
    task automatic expectFrom(input logic [15:0] start, input int count);
        logic [15:0] p;
        instr_t      e;
        int          n;
        p = start;
        for (int k = 0; k < count; k++) begin
            e = '0;
            e.pc = p;
            e.op = mem[p];
            p = p + 16'd1;
            if (e.op == 8'hCB) begin
                e.cb    = 1'b1;
                e.cb_op = mem[p];
                p = p + 16'd1;
            end else begin
                n = modelLen(e.op);
                if (n >= 1) begin e.imm[7:0]  = mem[p]; p = p + 16'd1; end
                if (n == 2) begin e.imm[15:8] = mem[p]; p = p + 16'd1; end
            end
            exp_q.push_back(e);
        end
    endtask

    // Memory: acks after wait_states idle request cycles; junk data when not acking.
    int wait_cnt = 0;
    always @(negedge clk) begin
        if (mem_rd_req) begin
            if (wait_cnt >= wait_states) begin
                mem_rd_ack  = 1'b1;
                mem_rd_data = mem[mem_addr];
                wait_cnt    = 0;
            end else begin
                mem_rd_ack  = 1'b0;
                mem_rd_data = 8'hA5;
                wait_cnt++;
            end
        end else begin
            mem_rd_ack  = 1'b0;
            mem_rd_data = 8'hA5;
            wait_cnt    = 0;
        end
    end

    // Every cycle: address held during a pending request; a presented instruction matches the model.
    int          hold = 0;
    logic        prev_pending = 1'b0;
    logic [15:0] prev_addr = '0;
    always begin
        @(negedge clk);
        #1;
        if (prev_pending && mem_rd_req && !rst) checkOutput("mem_addr_stable", mem_addr, prev_addr);
        prev_pending = mem_rd_req && !mem_rd_ack && !jump_en && !rst;
        prev_addr    = mem_addr;
        if (op_valid && exp_q.size() > 0) begin
            checkOutput("op", op, exp_q[0].op);
            checkOutput("op_cb", op_cb, exp_q[0].cb);
            checkOutput("cb_op", cb_op, exp_q[0].cb_op);
            checkOutput("imm", imm, exp_q[0].imm);
            checkOutput("op_pc", op_pc, exp_q[0].pc);
            if (hold >= ready_delay && !jump_en && !rst) begin
                op_ready = 1'b1;
                last = '{op: op, cb: op_cb, cb_op: cb_op, imm: imm, pc: op_pc};
                issued++;
                void'(exp_q.pop_front());
                hold = 0;
            end else begin
                op_ready = 1'b0;
                hold++;
            end
        end else begin
            op_ready = 1'b0;
            hold = 0;
        end
    end

    // One-cycle redirect pulse; entered and left on a falling edge.
    task automatic applyStimulus(input logic [15:0] target);
        jump_en   = 1'b1;
        jump_addr = target;
        @(negedge clk);
        jump_en   = 1'b0;
    endtask

    task automatic waitDrain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain_timeout", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd0);
        @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_mem_rd_req"}, mem_rd_req, 1'b0);
        checkOutput({tag, "_op_valid"}, op_valid, 1'b0);
        checkOutput({tag, "_op"}, op, 8'h00);
        checkOutput({tag, "_op_cb"}, op_cb, 1'b0);
        checkOutput({tag, "_cb_op"}, cb_op, 8'h00);
        checkOutput({tag, "_imm"}, imm, 16'h0000);
        checkOutput({tag, "_op_pc"}, op_pc, 16'h0000);
        checkOutput({tag, "_mem_addr"}, mem_addr, 16'h0000);
    endtask

    // Walk falling edges until the DUT requests addr; op_valid must stay low meanwhile.
    task automatic waitForReq(input logic [15:0] addr, input string tag);
        int n;
        n = 0;
        while (!(mem_rd_req && mem_addr == addr) && n < 20) begin
            checkOutput({tag, "_no_issue"}, op_valid, 1'b0);
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_reached"}, (n < 20) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        last = '0;

        // Reset, then two NOPs from 0x0000 with zero-wait memory.
        @(negedge clk);
        @(negedge clk);
        checkResetState("reset");
        expectFrom(16'h0000, 2);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("first_req", mem_rd_req, 1'b1);
        checkOutput("first_req_valid", op_valid, 1'b0);
        @(negedge clk);
        checkOutput("nop_valid_latency", op_valid, 1'b1);
        waitDrain(50);
        checkOutput("nop_second_pc", last.pc, 16'h0001);
        checkOutput("nop_second_op", last.op, 8'h00);

        // LD BC,0x1234 at 0x0100.
        mem[16'h0100] = 8'h01; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h12;
        applyStimulus(16'h0100);
        expectFrom(16'h0100, 1);
        waitDrain(50);
        checkOutput("ldbc_next_addr", mem_addr, 16'h0103);
        checkOutput("ldbc_next_req", mem_rd_req, 1'b1);
        checkOutput("ldbc_imm", last.imm, 16'h1234);
        checkOutput("ldbc_op", last.op, 8'h01);
        checkOutput("ldbc_pc", last.pc, 16'h0100);

        // CB-prefixed BIT 7,H at 0x0120.
        mem[16'h0120] = 8'hCB; mem[16'h0121] = 8'h7C;
        applyStimulus(16'h0120);
        expectFrom(16'h0120, 1);
        waitDrain(50);
        checkOutput("cb_next_addr", mem_addr, 16'h0122);
        checkOutput("cb_flag", last.cb, 1'b1);
        checkOutput("cb_op_val", last.cb_op, 8'h7C);
        checkOutput("cb_imm", last.imm, 16'h0000);

        // Slow memory and slow decode: 3 wait states per byte, ready low 4 cycles.
        mem[16'h0130] = 8'h3E; mem[16'h0131] = 8'h55;
        mem[16'h0132] = 8'h21; mem[16'h0133] = 8'hEF; mem[16'h0134] = 8'hBE;
        mem[16'h0135] = 8'h00;
        wait_states = 3;
        ready_delay = 4;
        issued = 0;
        applyStimulus(16'h0130);
        expectFrom(16'h0130, 3);
        waitDrain(300);
        checkOutput("slow_issue_count", issued, 3);
        checkOutput("slow_last_pc", last.pc, 16'h0135);
        wait_states = 0;
        ready_delay = 0;

        // Redirect while fetching the high immediate of JP 0x0300.
        mem[16'h0200] = 8'hC3; mem[16'h0201] = 8'h00; mem[16'h0202] = 8'h03;
        mem[16'h0150] = 8'h3C;
        applyStimulus(16'h0200);
        waitForReq(16'h0202, "jp");
        jump_en   = 1'b1;
        jump_addr = 16'h0150;
        @(negedge clk);
        jump_en = 1'b0;
        checkOutput("jump_no_valid", op_valid, 1'b0);
        checkOutput("jump_addr", mem_addr, 16'h0150);
        checkOutput("jump_req", mem_rd_req, 1'b1);
        expectFrom(16'h0150, 1);
        waitDrain(50);
        checkOutput("jump_issue_pc", last.pc, 16'h0150);
        checkOutput("jump_issue_op", last.op, 8'h3C);

        // LD A,0x55 straddling the wrap, then reset while fetching the next instruction.
        mem[16'hFFFF] = 8'h3E; mem[16'h0000] = 8'h55;
        mem[16'h0001] = 8'h01; mem[16'h0002] = 8'hAA; mem[16'h0003] = 8'hBB;
        applyStimulus(16'hFFFF);
        expectFrom(16'hFFFF, 1);
        waitDrain(50);
        checkOutput("wrap_next_addr", mem_addr, 16'h0001);
        checkOutput("wrap_imm", last.imm, 16'h0055);
        checkOutput("wrap_pc", last.pc, 16'hFFFF);
        waitForReq(16'h0002, "rst");
        rst = 1'b1;
        @(negedge clk);
        checkResetState("midreset");
        @(negedge clk);
        expectFrom(16'h0000, 1);
        rst = 1'b0;
        waitDrain(50);
        checkOutput("after_reset_op", last.op, 8'h55);
        checkOutput("after_reset_pc", last.pc, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 200000");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
